// File: rtl/aes_top.sv
// Iterative AES-128 encryption core: one round per clock, with the round key expanded on the fly.
// Byte 0 of every 128-bit bus sits in bits 127..120, and the state is stored column-major.
module aes_top (
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t       fsm;
  logic [3:0]   round_cnt;
  logic [127:0] st;
  logic [127:0] rk;
  logic [127:0] next_rk;
  logic [127:0] round_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // The multiplicative inverse is x^254, built as the product of x^2, x^4, ..., x^128.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] c);
    case (c)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;
    t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   b  [16];
    logic [7:0]   sr [16];
    logic [7:0]   m  [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    // ShiftRows: row rr of column c takes the byte from column (c + rr) mod 4.
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        sr[rr+4*c] = b[rr+4*((c+rr)%4)];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      m[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      m[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      m[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      m[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = (last ? sr[i] : m[i]) ^ k[127-8*i -: 8];
    return r;
  endfunction

  always_comb begin
    next_rk   = key_step(rk, rcon(round_cnt));
    round_out = aes_round(st, next_rk, round_cnt == 4'd10);
  end

  // Handshake: AES_en is a level request that is sampled only in IDLE, and inputs are
  // captured on that edge. AES_data_out_valid pulses high for one cycle when AES_data_out
  // takes a new ciphertext. AES_data_out holds that value until the next pulse.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      fsm                <= IDLE;
      round_cnt          <= 4'd0;
      st                 <= '0;
      rk                 <= '0;
      AES_data_out       <= '0;
      AES_data_out_valid <= 1'b0;
    end else begin
      AES_data_out_valid <= 1'b0;
      case (fsm)
        IDLE: begin
          if (AES_en) begin
            st        <= AES_data_in ^ AES_key_in;
            rk        <= AES_key_in;
            round_cnt <= 4'd1;
            fsm       <= BUSY;
          end
        end
        BUSY: begin
          st <= round_out;
          rk <= next_rk;
          if (round_cnt == 4'd10) begin
            AES_data_out       <= round_out;
            AES_data_out_valid <= 1'b1;
            round_cnt          <= 4'd0;
            fsm                <= IDLE;
          end else begin
            round_cnt <= round_cnt + 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_top.sv
// Self-checking bench for aes_top: it runs a byte-array AES-128 reference and a start/latency model,
// and compares the DUT outputs against them on every cycle.
module tb_aes_top;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [127:0] din;
  logic [127:0] key;
  logic [127:0] dout;
  logic         valid;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sbox_t [256];

  // Model state: the expected ciphertexts and the cycles on which they must appear.
  logic [127:0] exp_q [$];
  int           due_q [$];
  logic [127:0] m_out   = '0;
  logic         m_valid = 1'b0;
  int           cyc     = 0;
  int           free_at = 0;

  aes_top dut (
    .AES_clk           (clk),
    .AES_rst_n         (rst_n),
    .AES_en            (en),
    .AES_data_in       (din),
    .AES_key_in        (key),
    .AES_data_out      (dout),
    .AES_data_out_valid(valid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = (aa << 1) ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
              ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[row+4*c] = s[row+4*((c+row)%4)];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          s[row+4*c] = (r == 10) ? t[row+4*c] :
                       gmul(8'h02, t[4*c+row]) ^ gmul(8'h03, t[4*c+(row+1)%4]) ^
                       t[4*c+(row+2)%4] ^ t[4*c+(row+3)%4];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a block starts when en is seen at an edge while the core is free,
  // its result is due 10 edges later, and the core is free again one edge after that.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        due_q.delete();
        m_out   = '0;
        m_valid = 1'b0;
        cyc     = 0;
        free_at = 0;
      end else begin
        cyc++;
        m_valid = 1'b0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
          m_out   = exp_q.pop_front();
          m_valid = 1'b1;
          void'(due_q.pop_front());
        end
        if (en && cyc >= free_at) begin
          exp_q.push_back(aes_ref(din, key));
          due_q.push_back(cyc + 10);
          free_at = cyc + 11;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("valid", {127'd0, valid}, {127'd0, m_valid});
      check("data_out", dout, m_out);
    end
  end

  task automatic run_block(input string name, input logic [127:0] pt, input logic [127:0] k,
                           input logic [127:0] exp, input bit scramble);
    int lat;
    lat = 0;
    @(negedge clk);
    en  = 1'b1;
    din = pt;
    key = k;
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 20 && lat == 0; i++) begin
      if (scramble) begin
        din = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      if (valid) lat = i + 1;
    end
    check({name, "_latency"}, 128'(lat), 128'd10);
    check(name, dout, exp);
    repeat (3) @(negedge clk);
  endtask

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial begin
    int pulses;
    int last_pulse;
    rst_n = 1'b0;
    en    = 1'b0;
    din   = '0;
    key   = '0;
    build_sbox();
    repeat (3) @(negedge clk);
    check("reset_out", dout, '0);
    check("reset_valid", {127'd0, valid}, 128'd0);
    #2 rst_n = 1'b1;

    check("ref_fips_b", aes_ref(PT_B, KEY_B), CT_B);
    check("ref_fips_c1", aes_ref(PT_C, KEY_C), CT_C);
    check("ref_zero", aes_ref('0, '0), CT_0);

    repeat (2) @(negedge clk);
    run_block("fips_b", PT_B, KEY_B, CT_B, 1'b0);
    run_block("fips_c1", PT_C, KEY_C, CT_C, 1'b0);
    run_block("zero", '0, '0, CT_0, 1'b0);
    run_block("busy_scramble", PT_C, KEY_C, CT_C, 1'b1);

    // Back-to-back: with en held high, a pulse must arrive every 11 cycles.
    @(negedge clk);
    en  = 1'b1;
    din = PT_B;
    key = KEY_B;
    pulses     = 0;
    last_pulse = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (valid) begin
        pulses++;
        check("b2b_gap", 128'(i - last_pulse), (pulses == 1) ? 128'd11 : 128'd11);
        check("b2b_ct", dout, CT_B);
        last_pulse = i;
      end
    end
    check("b2b_pulses", 128'(pulses), 128'd5);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      din = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    check("hold_after_en_low", dout, CT_B);

    // Reset in mid-encryption: the outputs clear at once and no pulse follows.
    @(negedge clk);
    en  = 1'b1;
    din = PT_C;
    key = KEY_C;
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_out", dout, '0);
    check("midrun_reset_valid", {127'd0, valid}, 128'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("post_reset_out", dout, '0);

    // Random traffic: sparse requests, with inputs changing every cycle.
    for (int i = 0; i < 500; i++) begin
      en  = ($urandom_range(0, 3) == 0);
      din = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    en = 1'b0;
    repeat (15) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
